// File: rtl/fp16_sqrt_driver.sv
// Upstream controller for the FP16 square-root core: one operation in flight, valid/ready on both sides.
// Define SQRT_DRV_TIMEOUT_EN to abort a WAIT that outlasts TIMEOUT_CYCLES.
module fp16_sqrt_driver #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] IN_DATA,
    input  logic        IN_VALID,
    output logic        IN_READY,
    output logic [15:0] OUT_DATA,
    output logic [2:0]  OUT_FLAGS,
    output logic        OUT_TIMEOUT,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    inout  wire  [15:0] SQ_DATA,
    output logic        SQ_ENABLE,
    input  logic        SQ_IS_NAN,
    input  logic        SQ_IS_PINF,
    input  logic        SQ_IS_NINF,
    input  logic        SQ_RESULT
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    state_t      state, state_n;
    logic [15:0] op_q;
    logic        drive_q;
    logic        capture, abort, limit;

    if (TIMEOUT_CYCLES < 14) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 14");
    end

    assign IN_READY = (state == IDLE) && !RESET;
    assign SQ_DATA  = drive_q ? op_q : 16'hzzzz;

    always_comb begin
        state_n = state;
        capture = 1'b0;
        abort   = 1'b0;
        case (state)
            IDLE: if (IN_VALID && IN_READY) state_n = LOAD;
            LOAD: state_n = WAIT;
            WAIT: begin
                // A result arriving on the limit edge takes priority over the abort
                if (SQ_RESULT) begin
                    capture = 1'b1;
                    state_n = DONE;
                end else if (limit) begin
                    abort   = 1'b1;
                    state_n = DONE;
                end
            end
            DONE: if (OUT_READY) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            op_q      <= '0;
            drive_q   <= 1'b0;
            SQ_ENABLE <= 1'b0;
            OUT_VALID <= 1'b0;
            OUT_DATA  <= '0;
            OUT_FLAGS <= '0;
        end else begin
            state     <= state_n;
            // Bus is driven only in LOAD; WAIT starts released, giving the core a turnaround cycle
            drive_q   <= (state_n == LOAD);
            SQ_ENABLE <= (state_n == LOAD) || (state_n == WAIT);
            if (state == IDLE && IN_VALID && IN_READY)
                op_q <= IN_DATA;
            if (capture) begin
                OUT_DATA  <= SQ_DATA;
                OUT_FLAGS <= {SQ_IS_NINF, SQ_IS_PINF, SQ_IS_NAN};
                OUT_VALID <= 1'b1;
            end else if (abort) begin
                OUT_DATA  <= 16'h7E00;
                OUT_FLAGS <= 3'b001;
                OUT_VALID <= 1'b1;
            end else if (state == DONE && OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

`ifdef SQRT_DRV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] wait_cnt;

    // Limit is hit on the edge that would take the count to TIMEOUT_CYCLES
    assign limit = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wait_cnt    <= '0;
            OUT_TIMEOUT <= 1'b0;
        end else begin
            if (state != WAIT)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + CW'(1);
            if (capture)
                OUT_TIMEOUT <= 1'b0;
            else if (abort)
                OUT_TIMEOUT <= 1'b1;
        end
    end
`else
    assign limit       = 1'b0;
    assign OUT_TIMEOUT = 1'b0;
`endif

endmodule
